// File: rtl/hamming_burst_sched_if.sv
// Control/config and counter-facing signals of the burst scheduler, bundled as one bus.
interface hamming_burst_sched_if #(
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 16,
  parameter int BURST_W = 8
);
  logic                   start;
  logic                   abort;
  logic [LEN_W-1:0]       run_len;
  logic [LEN_W-1:0]       pause_len;
  logic [BURST_W-1:0]     num_bursts;
  logic [CNT_W-1:0]       counter_in;
  logic                   enable;
  logic                   busy;
  logic [CNT_W-1:0]       snapshot;
  logic [$clog2(CNT_W):0] hdist;
  logic                   snap_valid;
  logic                   done;

  modport master (
    output start, abort, run_len, pause_len, num_bursts, counter_in,
    input  enable, busy, snapshot, hdist, snap_valid, done
  );

  modport slave (
    input  start, abort, run_len, pause_len, num_bursts, counter_in,
    output enable, busy, snapshot, hdist, snap_valid, done
  );
endinterface

// File: rtl/hamming_burst_sched.sv
// Run/pause burst sequencer driving a counter enable; captures the counter after each
// burst and reports the Hamming distance to the previous capture.
module hamming_burst_sched #(
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 16,
  parameter int BURST_W = 8
) (
  input logic clk,
  input logic rst,
  hamming_burst_sched_if.slave bus
);
  localparam int HD_W = $clog2(CNT_W) + 1;

  typedef enum logic [2:0] {IDLE, RUN, CAPTURE, PAUSE, DONE} state_t;

  state_t             state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   run_lat;
  logic [LEN_W-1:0]   pause_lat;
  logic [BURST_W-1:0] bursts_left;
  logic [CNT_W-1:0]   prev_snap;
  logic               enable;
  logic               busy;
  logic [CNT_W-1:0]   snapshot;
  logic [HD_W-1:0]    hdist;
  logic               snap_valid;
  logic               done;

  function automatic logic [HD_W-1:0] popcount(input logic [CNT_W-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < CNT_W; i++) c = c + HD_W'(v[i]);
    return c;
  endfunction

  // cnt is loaded with the full length and leaves the state when it reads 1, so a
  // length of 2^LEN_W-1 fits without an extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      run_lat     <= '0;
      pause_lat   <= '0;
      bursts_left <= '0;
      prev_snap   <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      snapshot    <= '0;
      hdist       <= '0;
      snap_valid  <= 1'b0;
      done        <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state  <= IDLE;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              run_lat     <= bus.run_len;
              pause_lat   <= bus.pause_len;
              bursts_left <= bus.num_bursts;
              prev_snap   <= '0;
              busy        <= 1'b1;
              if (bus.run_len == '0 || bus.num_bursts == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= RUN;
                enable <= 1'b1;
                cnt    <= bus.run_len;
              end
            end
          end
          RUN: begin
            if (cnt == LEN_W'(1)) begin
              state  <= CAPTURE;
              enable <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CAPTURE: begin
            snapshot   <= bus.counter_in;
            hdist      <= popcount(bus.counter_in ^ prev_snap);
            prev_snap  <= bus.counter_in;
            snap_valid <= 1'b1;
            if (bursts_left > BURST_W'(1)) begin
              bursts_left <= bursts_left - 1'b1;
              if (pause_lat == '0) begin
                state  <= RUN;
                enable <= 1'b1;
                cnt    <= run_lat;
              end else begin
                state <= PAUSE;
                cnt   <= pause_lat;
              end
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          PAUSE: begin
            if (cnt == LEN_W'(1)) begin
              state  <= RUN;
              enable <= 1'b1;
              cnt    <= run_lat;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.enable     = enable;
  assign bus.busy       = busy;
  assign bus.snapshot   = snapshot;
  assign bus.hdist      = hdist;
  assign bus.snap_valid = snap_valid;
  assign bus.done       = done;
endmodule

// File: tb/tb_hamming_burst_sched.sv
// Scoreboard bench for hamming_burst_sched: directed sequences, expected captures queued
// at stimulus time and popped by an independent output monitor.
module tb_hamming_burst_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnt_clr = 1'b0;
  logic [31:0] counter = '0;

  typedef struct packed {
    logic        is_done;
    logic [31:0] snap;
    logic [5:0]  hd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycles;

  hamming_burst_sched_if #(.CNT_W(32), .LEN_W(16), .BURST_W(8)) bus ();

  hamming_burst_sched #(.CNT_W(32), .LEN_W(16), .BURST_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the enable-gated counter datapath; only the bench may clear it.
  always @(posedge clk) begin
    if (cnt_clr) counter <= '0;
    else if (bus.enable) counter <= counter + 1;
  end
  assign bus.counter_in = counter;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.snap_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_snap_valid actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("snap_order", e.is_done, 0);
          checkOutput("snapshot", bus.snapshot, e.snap);
          checkOutput("hdist", bus.hdist, e.hd);
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("done_order", e.is_done, 1);
        end
      end
    end
  end

  task automatic expectSnap(input logic [31:0] s, input logic [5:0] h);
    sb.push_back('{is_done: 1'b0, snap: s, hd: h});
  endtask

  task automatic expectDone();
    sb.push_back('{is_done: 1'b1, snap: '0, hd: '0});
  endtask

  task automatic clearCounter();
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first cycle after the start edge.
  task automatic applyStimulus(input int rl, input int pl, input int nb);
    @(negedge clk);
    bus.run_len    = 16'(rl);
    bus.pause_len  = 16'(pl);
    bus.num_bursts = 8'(nb);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (bus.busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.run_len = '0;
    bus.pause_len = '0;
    bus.num_bursts = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_enable", bus.enable, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_snapshot", bus.snapshot, 0);
    checkOutput("rst_hdist", bus.hdist, 0);
    checkOutput("rst_snap_valid", bus.snap_valid, 0);
    checkOutput("rst_done", bus.done, 0);
    rst = 1'b0;
    clearCounter();

    // Single 20-cycle burst
    expectSnap(32'd20, 6'd2);
    expectDone();
    applyStimulus(20, 0, 1);
    waitIdle(cycles);
    checkOutput("t1_busy_cycles", cycles, 22);
    checkOutput("t1_counter", counter, 20);

    // Three bursts of 5 with 3-cycle pauses
    clearCounter();
    expectSnap(32'd5, 6'd2);
    expectSnap(32'd10, 6'd4);
    expectSnap(32'd15, 6'd2);
    expectDone();
    applyStimulus(5, 3, 3);
    waitIdle(cycles);
    checkOutput("t2_busy_cycles", cycles, 25);
    checkOutput("t2_counter", counter, 15);

    // Degenerate configurations finish immediately
    expectDone();
    applyStimulus(0, 2, 4);
    waitIdle(cycles);
    checkOutput("t3a_busy_cycles", cycles, 1);
    expectDone();
    applyStimulus(6, 2, 0);
    waitIdle(cycles);
    checkOutput("t3b_busy_cycles", cycles, 1);
    checkOutput("t3_counter", counter, 15);

    // Abort on the 4th enable cycle
    clearCounter();
    applyStimulus(10, 0, 2);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("t4_enable", bus.enable, 0);
    checkOutput("t4_busy", bus.busy, 0);
    checkOutput("t4_counter", counter, 4);
    checkOutput("t4_snapshot", bus.snapshot, 15);
    checkOutput("t4_hdist", bus.hdist, 2);
    expectSnap(32'd7, 6'd3);
    expectDone();
    applyStimulus(3, 0, 1);
    waitIdle(cycles);
    checkOutput("t4_restart_cycles", cycles, 5);

    // Start and config changes while busy are ignored
    clearCounter();
    expectSnap(32'd4, 6'd1);
    expectSnap(32'd8, 6'd2);
    expectDone();
    applyStimulus(4, 2, 2);
    repeat (2) @(negedge clk);
    bus.run_len = 16'd9;
    bus.num_bursts = 8'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle(cycles);
    checkOutput("t5_busy_cycles", cycles, 10);
    checkOutput("t5_counter", counter, 8);

    // Asynchronous reset mid-PAUSE
    clearCounter();
    expectSnap(32'd3, 6'd2);
    applyStimulus(3, 5, 2);
    repeat (5) @(negedge clk);
    checkOutput("t6_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_enable", bus.enable, 0);
    checkOutput("t6_snapshot", bus.snapshot, 0);
    checkOutput("t6_hdist", bus.hdist, 0);
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset mid-RUN
    clearCounter();
    applyStimulus(8, 0, 1);
    @(negedge clk);
    checkOutput("t7_enable_before", bus.enable, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_enable", bus.enable, 0);
    checkOutput("t7_busy", bus.busy, 0);
    checkOutput("t7_done", bus.done, 0);
    checkOutput("t7_snap_valid", bus.snap_valid, 0);
    @(negedge clk) rst = 1'b0;

    clearCounter();
    expectSnap(32'd6, 6'd2);
    expectDone();
    applyStimulus(6, 0, 1);
    waitIdle(cycles);
    checkOutput("t8_busy_cycles", cycles, 8);
    repeat (2) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
